// File: rtl/tx_frame_buffer_if.sv
// rtl/tx_frame_buffer_if.sv - driver-side and transmitter-side signals of tx_frame_buffer
interface tx_frame_buffer_if;
  logic [7:0] data_tx;
  logic       wren_fifo_tx;
  logic       start_tx;
  logic [7:0] size_fifo_tx;
  logic       ready_tx;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       frame_done;
  logic       wr_dropped;

  modport master (
    output data_tx, wren_fifo_tx, start_tx, tx_ready,
    input  size_fifo_tx, ready_tx, tx_data, tx_valid, tx_last, frame_done, wr_dropped
  );

  modport slave (
    input  data_tx, wren_fifo_tx, start_tx, tx_ready,
    output size_fifo_tx, ready_tx, tx_data, tx_valid, tx_last, frame_done, wr_dropped
  );
endinterface

// File: rtl/tx_frame_buffer.sv
// rtl/tx_frame_buffer.sv - TX byte FIFO that drains whole frames on start_tx, then holds an inter-frame gap
module tx_frame_buffer #(
  parameter int ADDR_W     = 7,
  parameter int GAP_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  tx_frame_buffer_if.slave  bus
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [7:0] DEPTH_CNT = 8'(DEPTH);
  localparam int         GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t            r_state, w_next_state;
  logic [7:0]        r_mem [0:DEPTH-1];
  logic [ADDR_W-1:0] r_wptr, r_rptr, w_rptr_nxt;
  logic [7:0]        r_count, r_remaining, w_frame_len;
  logic [GAP_W-1:0]  r_gap;
  logic [7:0]        r_tx_data;
  logic              r_tx_valid, r_tx_last, r_frame_done, r_wr_dropped, r_ready;
  logic              w_wr_accept, w_handshake, w_last_hs, w_start;

  assign w_wr_accept = bus.wren_fifo_tx && (r_state == S_IDLE) && (r_count < DEPTH_CNT);
  assign w_handshake = r_tx_valid && bus.tx_ready;
  assign w_last_hs   = w_handshake && (r_remaining == 8'd1);
  assign w_start     = (r_state == S_IDLE) && bus.start_tx && ((r_count != 8'd0) || w_wr_accept);
  assign w_rptr_nxt  = r_rptr + 1'b1;
  assign w_frame_len = r_count + {7'd0, w_wr_accept};

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next_state = S_SEND;
      S_SEND:  if (w_last_hs) w_next_state = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (r_gap <= GAP_W'(1)) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Storage needs no reset: count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_wr_accept) r_mem[r_wptr] <= bus.data_tx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_remaining  <= '0;
      r_gap        <= '0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_tx_last    <= 1'b0;
      r_frame_done <= 1'b0;
      r_wr_dropped <= 1'b0;
      r_ready      <= 1'b1;
    end else begin
      r_state      <= w_next_state;
      r_ready      <= (w_next_state == S_IDLE);
      r_frame_done <= w_last_hs;
      r_wr_dropped <= bus.wren_fifo_tx && !w_wr_accept;

      if (w_wr_accept) r_wptr <= r_wptr + 1'b1;

      case ({w_wr_accept, w_handshake})
        2'b10:   r_count <= r_count + 8'd1;
        2'b01:   r_count <= r_count - 8'd1;
        default: r_count <= r_count;
      endcase

      // The head byte stays in the FIFO until its handshake; an empty FIFO forwards the coincident write.
      if (w_start) begin
        r_remaining <= w_frame_len;
        r_tx_valid  <= 1'b1;
        r_tx_data   <= (r_count == 8'd0) ? bus.data_tx : r_mem[r_rptr];
        r_tx_last   <= (w_frame_len == 8'd1);
      end else if (w_handshake) begin
        r_rptr      <= w_rptr_nxt;
        r_remaining <= r_remaining - 8'd1;
        if (r_remaining == 8'd1) begin
          r_tx_valid <= 1'b0;
          r_tx_last  <= 1'b0;
        end else begin
          r_tx_data <= r_mem[w_rptr_nxt];
          r_tx_last <= (r_remaining == 8'd2);
        end
      end

      if (w_last_hs)
        r_gap <= GAP_W'(GAP_CYCLES);
      else if (r_state == S_GAP)
        r_gap <= r_gap - 1'b1;
    end
  end

  assign bus.size_fifo_tx = r_count;
  assign bus.ready_tx     = r_ready;
  assign bus.tx_data      = r_tx_data;
  assign bus.tx_valid     = r_tx_valid;
  assign bus.tx_last      = r_tx_last;
  assign bus.frame_done   = r_frame_done;
  assign bus.wr_dropped   = r_wr_dropped;

endmodule

// File: tb/tb_tx_frame_buffer.sv
// tb/tb_tx_frame_buffer.sv - directed and random stimulus against a queue-based frame model
module tb_tx_frame_buffer;
  localparam int GAP   = 16;
  localparam int DEPTH = 128;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tx_frame_buffer_if bus ();

  tx_frame_buffer #(.ADDR_W(7), .GAP_CYCLES(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: bytes held by the buffer, whether a frame is going out, cycles of gap left.
  byte unsigned m_q[$];
  bit  m_idle    = 1'b1;
  bit  m_sending = 1'b0;
  int  m_len     = 0;
  int  m_gap     = 0;
  int  m_sent    = 0;
  bit  m_done    = 1'b0;
  bit  m_drop    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    byte unsigned dummy;
    m_done = 1'b0;
    m_drop = 1'b0;
    if (reset) begin
      m_q.delete();
      m_idle = 1'b1; m_sending = 1'b0; m_len = 0; m_gap = 0; m_sent = 0;
      return;
    end
    if (m_idle) begin
      if (bus.wren_fifo_tx) begin
        if (m_q.size() < DEPTH) m_q.push_back(bus.data_tx);
        else m_drop = 1'b1;
      end
      if (bus.start_tx && m_q.size() > 0) begin
        m_idle = 1'b0; m_sending = 1'b1; m_len = m_q.size(); m_sent = 0;
      end
    end else begin
      m_drop = bus.wren_fifo_tx;
      if (m_sending) begin
        if (bus.tx_ready) begin
          dummy = m_q.pop_front();
          m_len--; m_sent++;
          if (m_len == 0) begin
            m_sending = 1'b0; m_done = 1'b1; m_gap = GAP; m_idle = (GAP == 0);
          end
        end
      end else begin
        m_gap--;
        if (m_gap == 0) m_idle = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    chk("ready_tx", 32'(bus.ready_tx), 32'(m_idle));
    chk("size_fifo_tx", 32'(bus.size_fifo_tx), 32'(m_q.size()));
    chk("tx_valid", 32'(bus.tx_valid), 32'(m_sending));
    if (m_sending) begin
      chk("tx_data", 32'(bus.tx_data), 32'(m_q[0]));
      chk("tx_last", 32'(bus.tx_last), 32'(m_len == 1));
    end else begin
      chk("tx_last_idle", 32'(bus.tx_last), 32'd0);
    end
    chk("frame_done", 32'(bus.frame_done), 32'(m_done));
    chk("wr_dropped", 32'(bus.wr_dropped), 32'(m_drop));
  endtask

  task automatic step(input bit wr, input byte unsigned din, input bit st, input bit rdy, input bit rst);
    bus.wren_fifo_tx = wr;
    bus.data_tx      = din;
    bus.start_tx     = st;
    bus.tx_ready     = rdy;
    reset            = rst;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_cycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, rdy, 1'b0);
  endtask

  task automatic drain(input bit rdy);
    for (int i = 0; i < 400 && !m_idle; i++) step(1'b0, 8'h00, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    bus.wren_fifo_tx = 1'b0;
    bus.data_tx      = 8'h00;
    bus.start_tx     = 1'b0;
    bus.tx_ready     = 1'b0;
    reset            = 1'b1;

    // Reset state
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("tx_data_reset", 32'(bus.tx_data), 32'd0);
    idle_cycles(2, 1'b1);

    // Three-byte frame, full throughput, then the gap
    step(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
    chk("size_three", 32'(bus.size_fifo_tx), 32'd3);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    idle_cycles(GAP + 6, 1'b1);

    // Stalled three-byte frame
    step(1'b1, 8'h44, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h66, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b0, (i % 3) == 0, 1'b0);
    drain(1'b1);

    // Full-depth frame plus one dropped write
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0);
    chk("size_full", 32'(bus.size_fifo_tx), 32'd128);
    step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    drain(1'b1);
    chk("size_after_full", 32'(bus.size_fifo_tx), 32'd0);

    // Start with an empty FIFO, then a write coincident with start
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
    drain(1'b1);

    // Writes and starts during SEND and GAP are discarded
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'hE1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'hE2, 1'b1, 1'b1, 1'b0);
    idle_cycles(4, 1'b1);
    step(1'b1, 8'hE3, 1'b1, 1'b1, 1'b0);
    step(1'b1, 8'hE4, 1'b0, 1'b1, 1'b0);
    drain(1'b1);
    step(1'b1, 8'hD1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'hD2, 1'b1, 1'b1, 1'b0);
    drain(1'b1);

    // Reset on the second byte of a five-byte frame
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("size_after_reset", 32'(bus.size_fifo_tx), 32'd0);
    chk("tx_valid_after_reset", 32'(bus.tx_valid), 32'd0);
    step(1'b1, 8'h81, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h82, 1'b1, 1'b1, 1'b0);
    drain(1'b1);

    // Random traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(1, 0) == 1, 8'($urandom), $urandom_range(7, 0) == 0,
           $urandom_range(3, 0) != 0, $urandom_range(299, 0) == 0);
    drain(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
